drops: RTL and testbench
========================

# drops

Seven-segment "falling drops" counter for the Tiny Tapeout user slot. Two push-button inputs add or drain drops from a 0–9 tank level. The level is shown as a decimal digit on the segment outputs. When the animation feature is compiled in, each change plays a short drop animation first. The block is the top-level user module and also exports the level in binary on the bidirectional pins.

## Interface
- `PRESCALE`, default 16: clock cycles per animation frame; legal range 1..65535.
- `clk` in, 1 bit: system clock; all state on the rising edge.
- `rst` in, 1 bit: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `ena` in, 1 bit: slot enable; ignored by the logic.
- `ui_in` in, 8 bits: bit1 is ADD, bit0 is DRAIN; bits 7:2 are ignored.
- `uo_out` out, 8 bits:
  - bits 6:0 are segments a..g, bit0 = a, active-high.
  - bit7 is the animation-busy flag.
- `uio_out` out, 8 bits: bits 3:0 are the level in binary; bits 7:4 are 0.
- `uio_oe` out, 8 bits: constant 8'hFF.

## Operation
- ADD and DRAIN each pass through a 2-flop synchronizer plus a delay flop.
- An event is the rising edge of the synchronized signal, i.e. sync=1 and delayed=0. Falling edges are ignored.
- `level` is 4 bits, range 0..9, reset value 0.
  - ADD event alone: `level` increments, saturating at 9.
  - DRAIN event alone: `level` decrements, saturating at 0.
  - Both events on the same cycle: no change, and no animation starts.
  - An event at saturation changes nothing, but still triggers the animation.
- Digit encoding for segments 6:0 is 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Levels above 9 are unreachable; decode them as 00.
- Animation (with `DROPS_ANIM_EN` only):
  - Any single event starts a 3-frame sequence: frame0 = segment a (01), frame1 = g (40), frame2 = d (08).
  - Each frame lasts exactly `PRESCALE` cycles. The digit is shown afterwards.
  - `uo_out[7]` is 1 throughout the animation.
  - A new event during an animation restarts it at frame0 with the prescale counter cleared.
- Animation FSM states:
  - IDLE: shows the digit. Goes to F0 on an event.
  - F0 → F1 → F2 → IDLE, each transition when the prescale counter reaches `PRESCALE-1`.
- Reset values:
  - `uo_out` = 8'h3F (digit 0, not busy).
  - `uio_out` = 0.
  - Synchronizer flops = 0.
  - FSM = IDLE, prescale counter = 0.
- Reset asserted mid-animation returns everything to reset values on that edge.
- All outputs are registered.

## Timing
- An input first sampled high at edge k produces the event at edge k+2; `level` and the FSM update on edge k+2.
- Output registers update one edge later, at k+3. `uio_out` shows the new level after edge k+3.
- Frame durations count from the edge on which the FSM enters the frame.
- Total animation length is 3·`PRESCALE` cycles. With the default that is 48 cycles.
- A held input yields one event only. A re-press needs the input low for at least 1 sampled cycle.

## Configuration
- `DROPS_ANIM_EN` defined: the FSM, prescaler and busy flag are built as described above.
- Not defined:
  - No FSM or prescaler.
  - `uo_out[6:0]` always shows the digit.
  - `uo_out[7]` is constant 0.
  - Level and event behaviour and latencies are unchanged.

## Structure
- Shared package `drops_pkg`:
  - Digit-to-segment constant table.
  - Frame segment constants `SEG_A`, `SEG_G`, `SEG_D`.
  - FSM state typedef {IDLE, F0, F1, F2}.
  - `LEVEL_MAX` = 9.
- One sub-module: `drops_edge`, a synchronizer plus rising-edge detector. It is instantiated twice, once for ADD and once for DRAIN.

## Test plan
- Reset with `ui_in`=0: `uo_out`=8'h3F, `uio_out`=0, `uio_oe`=FF.
- Set `ui_in`=02 for 200 cycles:
  - level becomes 1 and `uio_out`=01.
  - With `DROPS_ANIM_EN`, `uo_out` shows 81, C0, 88 for 16 cycles each.
  - The display then settles at 06.
- Then `ui_in`=01 (ADD falls, DRAIN rises): level is 0 and `uo_out` settles at 3F. Repeat the 02/01 pair and get the same result.
- Send 12 ADD pulses: level saturates at 9 and `uo_out` settles at 6F. One DRAIN pulse at level 0 leaves level 0.
- `ui_in`=03 applied on a single edge: level unchanged and no busy flag.
- Assert `rst` during frame1: on the next edge `uo_out`=3F, and the FSM is IDLE.

Source files
------------

// File: rtl/drops_pkg.sv
// Shared constants and types for the falling-drops seven-segment counter.
// Holds the digit segment table, animation frame segments, FSM state type
// and the tank level ceiling.
package drops_pkg;

  localparam logic [3:0] LEVEL_MAX = 4'd9;

  // Animation frame patterns, segment a = bit0.
  localparam logic [6:0] SEG_A = 7'h01;
  localparam logic [6:0] SEG_G = 7'h40;
  localparam logic [6:0] SEG_D = 7'h08;

  // Active-high segment patterns for digits 0..9.
  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F0   = 2'd1,
    F1   = 2'd2,
    F2   = 2'd3
  } anim_state_t;

  // Levels above LEVEL_MAX cannot occur; blank them rather than index past the table.
  function automatic logic [6:0] digit_seg(input logic [3:0] lvl);
    if (lvl > LEVEL_MAX) begin
      return 7'h00;
    end
    return DIGIT_SEG[lvl];
  endfunction

endpackage

// File: rtl/drops_edge.sv
// Push-button synchronizer plus rising-edge detector.
// Ports: clk, rst (sync, active-high), din (async button), rise (one-cycle pulse).
// rise is combinational from flops: high while synced=1 and delayed=0.
module drops_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

endmodule

// File: rtl/drops.sv
// Falling-drops tank counter (0..9) shown on a seven-segment digit.
// Ports: clk, rst (sync, active-high), ena (unused), ui_in[1]=ADD, ui_in[0]=DRAIN,
// uo_out = {busy, segments g..a}, uio_out[3:0] = level, uio_oe = 8'hFF.
// Build macro DROPS_ANIM_EN adds the 3-frame drop animation, prescaler and busy flag.
module drops
  import drops_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       add_ev;
  logic       drn_ev;
  logic       single_ev;
  logic [3:0] level;
  logic [6:0] seg_nxt;
  logic       busy_nxt;

  // Inputs that have no function still need a sink.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:2], 16'(PRESCALE)};

  drops_edge u_add (
    .clk  (clk),
    .rst  (rst),
    .din  (ui_in[1]),
    .rise (add_ev)
  );

  drops_edge u_drn (
    .clk  (clk),
    .rst  (rst),
    .din  (ui_in[0]),
    .rise (drn_ev)
  );

  // Simultaneous ADD and DRAIN cancel: no level change, no animation.
  assign single_ev = add_ev ^ drn_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 4'd0;
    end else if (add_ev && !drn_ev) begin
      if (level < LEVEL_MAX) level <= level + 4'd1;
    end else if (drn_ev && !add_ev) begin
      if (level != 4'd0) level <= level - 4'd1;
    end
  end

`ifdef DROPS_ANIM_EN
  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

  anim_state_t state;
  anim_state_t state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    seg_nxt   = digit_seg(level);
    busy_nxt  = 1'b0;

    // A fresh event always restarts from frame0, even mid-animation
    // (including saturated events that leave the level untouched).
    if (single_ev) begin
      state_nxt = F0;
      cnt_nxt   = 16'd0;
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = 16'd0;
        case (state)
          F0:      state_nxt = F1;
          F1:      state_nxt = F2;
          default: state_nxt = IDLE;
        endcase
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end

    // Display follows the current state; output flops add one cycle.
    case (state)
      F0: begin
        seg_nxt  = SEG_A;
        busy_nxt = 1'b1;
      end
      F1: begin
        seg_nxt  = SEG_G;
        busy_nxt = 1'b1;
      end
      F2: begin
        seg_nxt  = SEG_D;
        busy_nxt = 1'b1;
      end
      default: begin
        seg_nxt  = digit_seg(level);
        busy_nxt = 1'b0;
      end
    endcase
  end
`else
  always_comb begin
    seg_nxt  = digit_seg(level);
    busy_nxt = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out  <= 8'h3F;
      uio_out <= 8'h00;
    end else begin
      uo_out  <= {busy_nxt, seg_nxt};
      uio_out <= {4'h0, level};
    end
  end

  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_drops.sv
// Scoreboard bench for drops: every driven cycle pushes the expected
// {uo_out, uio_out, uio_oe} seen after the coming edge; a monitor pops and
// compares on each falling edge.
module tb_drops;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  drops #(.PRESCALE(P)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [23:0] v;
    string       tag;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: tank level, edge where the latest animation began,
  // and the last three sampled button values per input.
  logic [6:0] digit_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int    m_level = 0;
  int    m_start = -1;
  int    m_edge  = 0;
  logic  a1 = 0, a2 = 0, a3 = 0;
  logic  d1 = 0, d2 = 0, d3 = 0;
  string phase = "reset";

  task automatic step(input logic r, input logic [7:0] ui);
    exp_t e;
    logic [7:0] uo_e;
    logic ae, de;
    int n;
    rst   = r;
    ui_in = ui;
    n = m_edge + 1;
    // Output after edge n reflects model state after edge n-1.
    uo_e = {1'b0, digit_tbl[m_level]};
`ifdef DROPS_ANIM_EN
    if (m_start >= 0 && (n - 1 - m_start) / P < 3) begin
      case ((n - 1 - m_start) / P)
        0:       uo_e = 8'h81;
        1:       uo_e = 8'hC0;
        default: uo_e = 8'h88;
      endcase
    end
`endif
    if (r) e.v = {8'h3F, 8'h00, 8'hFF};
    else   e.v = {uo_e, 4'h0, 4'(m_level), 8'hFF};
    e.tag = phase;
    e.cyc = n;
    exp_q.push_back(e);
    // Advance model across edge n.
    if (r) begin
      m_level = 0;
      m_start = -1;
      {a1, a2, a3, d1, d2, d3} = '0;
    end else begin
      ae = a2 & ~a3;
      de = d2 & ~d3;
      if (ae ^ de) begin
        if (ae) m_level = (m_level < 9) ? m_level + 1 : 9;
        else    m_level = (m_level > 0) ? m_level - 1 : 0;
        m_start = n;
      end
      a3 = a2; a2 = a1; a1 = ui[1];
      d3 = d2; d2 = d1; d1 = ui[0];
    end
    m_edge = n;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] ui, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, ui);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({uo_out, uio_out, uio_oe} === e.v) begin
          passed++;
        end else begin
          $display("FAIL %s edge %0d: got uo=%02h uio=%02h oe=%02h, want uo=%02h uio=%02h oe=%02h",
                   e.tag, e.cyc, uo_out, uio_out, uio_oe, e.v[23:16], e.v[15:8], e.v[7:0]);
        end
      end
    end
  end

  initial begin : stimulus
    ena   = 1'b1;
    rst   = 1'b1;
    ui_in = 8'h00;

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00);
    hold(8'h00, 4);

    phase = "add_hold";
    hold(8'h02, 200);
    phase = "drain_swap";
    hold(8'h01, 200);
    phase = "add_hold2";
    hold(8'h02, 200);
    phase = "drain_swap2";
    hold(8'h01, 200);
    hold(8'h00, 4);

    phase = "add_pulses";
    for (int i = 0; i < 12; i++) begin
      hold(8'h02, 2);
      hold(8'h00, 55);
    end

    phase = "drain_to_zero";
    for (int i = 0; i < 10; i++) begin
      hold(8'h01, 1);
      hold(8'h00, 55);
    end

    phase = "both_one_edge";
    hold(8'h03, 1);
    hold(8'h00, 60);

    phase = "rst_in_frame1";
    hold(8'h02, 3);
    hold(8'h00, P + 4);
    step(1'b1, 8'h00);
    hold(8'h00, 60);

    phase = "restart";
    hold(8'h02, 2);
    hold(8'h00, 10);
    hold(8'h02, 2);
    hold(8'h00, 70);

    phase = "random";
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        step(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        hold(8'($urandom_range(0, 255)), $urandom_range(1, 30));
      end
    end
    hold(8'h00, 60);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
